// File: rtl/shift_unit.sv
// Registered logical barrel shifter (SLL/SRL) for the ALU datapath.
// A single right-shift mux chain does the work; left shifts bit-reverse the
// operand on the way in and the result on the way out.
module shift_unit #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       i_1,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   shope,
  input  logic                   enable,
  output logic [WIDTH-1:0]       o
);

  logic [WIDTH-1:0] core_in;
  logic [WIDTH-1:0] core_out;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] o_q;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // Right-shift core: stage k shifts by 2**k when shamt[k] is set.
  always_comb begin
    core_in  = shope ? bit_rev(i_1) : i_1;
    core_out = core_in;
    for (int k = 0; k < int'(SHAMT_WIDTH); k++) begin
      if (shamt[k]) begin
        core_out = core_out >> (1 << k);
      end
    end
    shift_res = shope ? bit_rev(core_out) : core_out;
  end

  // Result register; a disabled unit drives zero so the ALU mux can OR it in.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= '0;
    end else if (!enable) begin
      o_q <= '0;
    end else begin
      o_q <= shift_res;
    end
  end

  assign o = o_q;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed vector table, enable/reset
// sequences, then back-to-back random operands against an arithmetic model.
module tb_shift_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  i_1;
  logic [4:0]    shamt;
  logic          shope;
  logic          enable;
  logic [W-1:0]  o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [4:0]   sh;
    logic         op;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[12];

  shift_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_1    (i_1),
    .shamt  (shamt),
    .shope  (shope),
    .enable (enable),
    .o      (o)
  );

  always #5 clk = ~clk;

  // Golden model in arithmetic form: SLL = a*2**s mod 2**W, SRL = floor(a/2**s).
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [4:0] s,
                                         input logic op, input logic en);
    logic [63:0] p;
    if (!en) return '0;
    if (op) begin
      p = {32'd0, a} * (64'd1 << s);
      return p[W-1:0];
    end
    return a / (32'd1 << s);
  endfunction

  task automatic check();
    logic [W-1:0] e;
    string        nm;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h with no expected value queued", o);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, o, e);
      end
    end
  endtask

  // Drive at negedge, push expectation, sample #1 after the capturing edge.
  task automatic drive(input logic r, input logic [W-1:0] a, input logic [4:0] s,
                       input logic op, input logic en, input logic [W-1:0] e,
                       input string nm);
    @(negedge clk);
    rst    = r;
    i_1    = a;
    shamt  = s;
    shope  = op;
    enable = en;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [4:0]   rs;
    logic         rop;
    logic         ren;

    vecs[0]  = '{32'd3,          5'd2,  1'b1, 32'd12,         "sll_3_2"};
    vecs[1]  = '{32'd3,          5'd2,  1'b0, 32'd0,          "srl_3_2"};
    vecs[2]  = '{32'd10000,      5'd6,  1'b0, 32'd156,        "srl_10000_6"};
    vecs[3]  = '{32'd4,          5'd9,  1'b0, 32'd0,          "srl_4_9"};
    vecs[4]  = '{32'd27,         5'd5,  1'b1, 32'd864,        "sll_27_5"};
    vecs[5]  = '{32'd3,          5'd15, 1'b1, 32'd98304,      "sll_3_15"};
    vecs[6]  = '{32'h00FFF000,   5'd22, 1'b1, 32'd0,          "sll_shift_out"};
    vecs[7]  = '{32'hDEADBEEF,   5'd0,  1'b1, 32'hDEADBEEF,   "sll_zero"};
    vecs[8]  = '{32'hDEADBEEF,   5'd0,  1'b0, 32'hDEADBEEF,   "srl_zero"};
    vecs[9]  = '{32'd1,          5'd31, 1'b1, 32'h80000000,   "sll_31"};
    vecs[10] = '{32'h80000000,   5'd31, 1'b0, 32'd1,          "srl_31"};
    vecs[11] = '{32'hF0F0_1234,  5'd4,  1'b0, 32'h0F0F_0123,  "srl_no_sign_ext"};

    rst = 1'b1; i_1 = '0; shamt = '0; shope = 1'b0; enable = 1'b0;

    drive(1'b1, 32'hA5A5A5A5, 5'd3, 1'b1, 1'b1, 32'd0, "reset_state");

    // Directed table: enabled, then same operands disabled.
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, vecs[i].a, vecs[i].sh, vecs[i].op, 1'b1, vecs[i].exp, vecs[i].name);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, vecs[i].a, vecs[i].sh, vecs[i].op, 1'b0, 32'd0, {vecs[i].name, "_dis"});
    end

    // Disabled output must not hold; re-enable resumes on the next cycle.
    drive(1'b0, 32'd27, 5'd5, 1'b1, 1'b1, 32'd864,   "pre_disable");
    drive(1'b0, 32'd27, 5'd5, 1'b1, 1'b0, 32'd0,     "disable_no_hold");
    drive(1'b0, 32'd3,  5'd15, 1'b1, 1'b1, 32'd98304, "reenable");

    // Reset has priority over enable and operands.
    drive(1'b1, 32'hFFFFFFFF, 5'd31, 1'b1, 1'b1, 32'd0,        "reset_priority");
    drive(1'b0, 32'hFFFFFFFF, 5'd31, 1'b1, 1'b1, 32'h80000000, "after_reset");

    // Back-to-back random traffic with forced shamt edge cases.
    for (int n = 0; n < 300; n++) begin
      ra  = $urandom;
      rs  = 5'($urandom_range(0, 31));
      if (n % 10 == 3) rs = 5'd0;
      if (n % 10 == 7) rs = 5'd31;
      rop = 1'($urandom_range(0, 1));
      ren = ($urandom_range(0, 7) != 0);
      drive(1'b0, ra, rs, rop, ren, model(ra, rs, rop, ren), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
